// File: rtl/led_seq_ctrl.sv
// LED bank mode/sequencing controller: manual count with auto-repeat, auto up/down
// counting and a ping-pong walker, all sequenced from one clock with registered outputs.
module led_seq_ctrl #(
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4,
    parameter int AUTO_PER   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       add,
    input  logic       sub,
    output logic [3:0] led,
    output logic       led4_r,
    output logic       led4_g,
    output logic       led4_b,
    output logic       led5_r,
    output logic       led5_g,
    output logic       led5_b
);

    localparam int MAXA = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int MAXP = (MAXA > AUTO_PER) ? MAXA : AUTO_PER;
    localparam int TW   = $clog2(MAXP + 1);

    localparam logic [1:0] MODE_MAN  = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_PING = 2'b11;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} hold_e;

    hold_e         hold_q, hold_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    count_q, count_d;
    logic [1:0]    pos_q, pos_d;
    logic          dirUp_q, dirUp_d;
    logic          paused_q, paused_d;
    logic          holdAdd_q, holdAdd_d;
    logic [1:0]    mode_q;
    logic          add_q, sub_q;

    logic [3:0] led_d;
    logic [2:0] rgb4_d, rgb5_d;
    logic       pressAdd, pressSub, bothPress, held, stepNow;

    always_comb begin
        hold_d    = hold_q;
        timer_d   = timer_q;
        count_d   = count_q;
        pos_d     = pos_q;
        dirUp_d   = dirUp_q;
        paused_d  = paused_q;
        holdAdd_d = holdAdd_q;
        stepNow   = 1'b0;
        held      = holdAdd_q ? add : sub;

        pressAdd  = add & ~add_q;
        pressSub  = sub & ~sub_q;
        bothPress = (pressAdd & pressSub) | (pressAdd & sub & sub_q) | (pressSub & add & add_q);

        if (sw != mode_q) begin
            timer_d  = '0;
            hold_d   = IDLE;
            paused_d = 1'b0;
        end else if (mode_q == MODE_MAN) begin
            if (bothPress) begin
                count_d = 4'd0;
                hold_d  = IDLE;
                timer_d = '0;
            end else if (pressAdd || pressSub) begin
                count_d   = pressAdd ? count_q + 4'd1 : count_q - 4'd1;
                hold_d    = DELAY;
                timer_d   = '0;
                holdAdd_d = pressAdd;
            end else if (hold_q != IDLE) begin
                if (!held) begin
                    hold_d  = IDLE;
                    timer_d = '0;
                end else if ((hold_q == DELAY  && timer_q == TW'(REPEAT_DLY - 1)) ||
                             (hold_q == REPEAT && timer_q == TW'(REPEAT_PER - 1))) begin
                    count_d = holdAdd_q ? count_q + 4'd1 : count_q - 4'd1;
                    hold_d  = REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end else begin
            // The timer only runs while not paused, so a resume continues the old period.
            if (pressAdd && pressSub) paused_d = ~paused_q;
            else if (pressSub)        paused_d = 1'b1;
            else if (pressAdd)        paused_d = 1'b0;

            if (!paused_q) begin
                if (timer_q == TW'(AUTO_PER - 1)) begin
                    timer_d = '0;
                    stepNow = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            if (stepNow) begin
                if (mode_q == MODE_UP) begin
                    count_d = count_q + 4'd1;
                end else if (mode_q == MODE_DOWN) begin
                    count_d = count_q - 4'd1;
                end else if (dirUp_q) begin
                    if (pos_q == 2'd3) begin
                        pos_d   = 2'd2;
                        dirUp_d = 1'b0;
                    end else begin
                        pos_d = pos_q + 2'd1;
                    end
                end else begin
                    if (pos_q == 2'd0) begin
                        pos_d   = 2'd1;
                        dirUp_d = 1'b1;
                    end else begin
                        pos_d = pos_q - 2'd1;
                    end
                end
            end
        end

        led_d     = (sw == MODE_PING) ? (4'b0001 << pos_d) : count_d;
        rgb4_d[2] = (sw == MODE_MAN)  || (sw == MODE_PING);
        rgb4_d[1] = (sw == MODE_UP)   || (sw == MODE_PING);
        rgb4_d[0] = (sw == MODE_DOWN) || (sw == MODE_PING);
        rgb5_d[2] = (sw != MODE_MAN) && paused_d;
        rgb5_d[1] = (sw != MODE_MAN) && !paused_d;
        rgb5_d[0] = (sw == MODE_MAN) && (hold_d == REPEAT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= IDLE;
            timer_q   <= '0;
            count_q   <= 4'd0;
            pos_q     <= 2'd0;
            dirUp_q   <= 1'b1;
            paused_q  <= 1'b0;
            holdAdd_q <= 1'b0;
            mode_q    <= MODE_MAN;
            add_q     <= 1'b0;
            sub_q     <= 1'b0;
            led       <= 4'd0;
            {led4_r, led4_g, led4_b} <= 3'b000;
            {led5_r, led5_g, led5_b} <= 3'b000;
        end else begin
            hold_q    <= hold_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            pos_q     <= pos_d;
            dirUp_q   <= dirUp_d;
            paused_q  <= paused_d;
            holdAdd_q <= holdAdd_d;
            mode_q    <= sw;
            add_q     <= add;
            sub_q     <= sub;
            led       <= led_d;
            {led4_r, led4_g, led4_b} <= rgb4_d;
            {led5_r, led5_g, led5_b} <= rgb5_d;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: reset, manual wrap/repeat/simultaneous, auto pause,
// auto-down and ping-pong sequencing, with hand-computed expectations.
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic       add;
    logic       sub;
    logic [3:0] led;
    logic       led4_r, led4_g, led4_b;
    logic       led5_r, led5_g, led5_b;

    int checks = 0;
    int errors = 0;

    led_seq_ctrl #(.REPEAT_DLY(8), .REPEAT_PER(4), .AUTO_PER(5)) dut (
        .clk(clk), .rst(rst), .sw(sw), .add(add), .sub(sub), .led(led),
        .led4_r(led4_r), .led4_g(led4_g), .led4_b(led4_b),
        .led5_r(led5_r), .led5_g(led5_g), .led5_b(led5_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [1:0] s, input logic a, input logic b);
        sw  = s;
        add = a;
        sub = b;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] rgb4();
        return {5'd0, led4_r, led4_g, led4_b};
    endfunction

    function automatic logic [7:0] rgb5();
        return {5'd0, led5_r, led5_g, led5_b};
    endfunction

    logic [3:0] ppExp [8];

    initial begin
        ppExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        rst = 1'b0;
        applyStimulus(2'b00, 1'b1, 1'b0);
        cycle(2);
        checkOutput("reset_led", {4'd0, led}, 8'h0);
        checkOutput("reset_led4", rgb4(), 8'h0);
        checkOutput("reset_led5", rgb5(), 8'h0);

        rst = 1'b1;
        cycle(1);
        checkOutput("held_press_led", {4'd0, led}, 8'h1);
        checkOutput("held_press_led4", rgb4(), 8'b100);
        applyStimulus(2'b00, 1'b0, 1'b0);
        cycle(1);

        applyStimulus(2'b00, 1'b0, 1'b1);
        cycle(1);
        checkOutput("sub_to_zero", {4'd0, led}, 8'h0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        cycle(1);
        applyStimulus(2'b00, 1'b0, 1'b1);
        cycle(1);
        checkOutput("sub_wrap", {4'd0, led}, 8'hF);
        applyStimulus(2'b00, 1'b0, 1'b0);
        cycle(1);
        applyStimulus(2'b00, 1'b1, 1'b0);
        cycle(1);
        checkOutput("add_wrap", {4'd0, led}, 8'h0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        cycle(1);

        applyStimulus(2'b00, 1'b1, 1'b0);
        cycle(1);
        checkOutput("rep_press", {4'd0, led}, 8'h1);
        cycle(7);
        checkOutput("rep_delay_led", {4'd0, led}, 8'h1);
        checkOutput("rep_delay_led5", rgb5(), 8'b000);
        cycle(1);
        checkOutput("rep_first", {4'd0, led}, 8'h2);
        checkOutput("rep_first_led5", rgb5(), 8'b001);
        cycle(4);
        checkOutput("rep_second", {4'd0, led}, 8'h3);
        cycle(4);
        checkOutput("rep_third", {4'd0, led}, 8'h4);
        cycle(3);
        checkOutput("rep_hold_led5", rgb5(), 8'b001);
        applyStimulus(2'b00, 1'b0, 1'b0);
        cycle(1);
        checkOutput("rep_release_led", {4'd0, led}, 8'h4);
        checkOutput("rep_release_led5", rgb5(), 8'b000);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 1'b1, 1'b0);
            cycle(1);
            applyStimulus(2'b00, 1'b0, 1'b0);
            cycle(1);
        end
        checkOutput("count_seven", {4'd0, led}, 8'h7);
        applyStimulus(2'b00, 1'b1, 1'b1);
        cycle(1);
        checkOutput("simul_clear", {4'd0, led}, 8'h0);
        cycle(15);
        checkOutput("simul_hold_led", {4'd0, led}, 8'h0);
        checkOutput("simul_hold_led5", rgb5(), 8'b000);
        applyStimulus(2'b00, 1'b0, 1'b0);
        cycle(1);

        applyStimulus(2'b01, 1'b0, 1'b0);
        cycle(1);
        checkOutput("up_change_led", {4'd0, led}, 8'h0);
        checkOutput("up_led4", rgb4(), 8'b010);
        checkOutput("up_led5", rgb5(), 8'b010);
        cycle(11);
        checkOutput("up_run", {4'd0, led}, 8'h2);
        applyStimulus(2'b01, 1'b0, 1'b1);
        cycle(1);
        checkOutput("pause_led5", rgb5(), 8'b100);
        applyStimulus(2'b01, 1'b0, 1'b0);
        cycle(20);
        checkOutput("pause_frozen", {4'd0, led}, 8'h2);
        checkOutput("pause_led5_hold", rgb5(), 8'b100);
        applyStimulus(2'b01, 1'b1, 1'b0);
        cycle(1);
        checkOutput("resume_led5", rgb5(), 8'b010);
        applyStimulus(2'b01, 1'b0, 1'b0);
        cycle(2);
        checkOutput("resume_before_step", {4'd0, led}, 8'h2);
        cycle(1);
        checkOutput("resume_step", {4'd0, led}, 8'h3);

        applyStimulus(2'b10, 1'b0, 1'b0);
        cycle(1);
        checkOutput("down_change_led", {4'd0, led}, 8'h3);
        checkOutput("down_led4", rgb4(), 8'b001);
        cycle(5);
        checkOutput("down_step", {4'd0, led}, 8'h2);

        applyStimulus(2'b11, 1'b0, 1'b0);
        cycle(1);
        checkOutput("ping_start", {4'd0, led}, {4'd0, ppExp[0]});
        checkOutput("ping_led4", rgb4(), 8'b111);
        for (int k = 1; k < 8; k++) begin
            cycle(4);
            checkOutput($sformatf("ping_hold_%0d", k), {4'd0, led}, {4'd0, ppExp[k-1]});
            cycle(1);
            checkOutput($sformatf("ping_step_%0d", k), {4'd0, led}, {4'd0, ppExp[k]});
        end

        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_led", {4'd0, led}, 8'h0);
        checkOutput("async_reset_led4", rgb4(), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
